// File: rtl/spi_oled_pkg.sv
// Shared types and constants for the OLED-style SPI slave receiver and its consumers.
package spi_oled_pkg;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;

endpackage

// File: rtl/spi_oled_rx_fifo.sv
// Synchronous FIFO of tagged bytes; a pop frees a slot for a push in the same cycle.
module spi_oled_rx_fifo
  import spi_oled_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  rx_entry_t din,
  input  logic      pop,
  output rx_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  rx_entry_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_pop;
  logic            do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spi_oled_rx.sv
// OLED-style 4-wire SPI write-only slave: oversampled pins, MSB-first bytes tagged with D/C, FIFO out.
// Optional byte statistics (cmd_cnt/data_cnt) are enabled with the macro SPI_OLED_RX_STATS_EN.
module spi_oled_rx
  import spi_oled_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int DC_SAMPLE_BIT = 7
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  input  logic        spi_dc,
  input  logic        spi_res,
  output logic [7:0]  rx_data,
  output logic        rx_dc,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overflow,
  output logic        rx_frame_err,
  input  logic        clr_err,
  output logic        busy
`ifdef SPI_OLED_RX_STATS_EN
  ,
  output logic [15:0] cmd_cnt,
  output logic [15:0] data_cnt
`endif
);

  localparam logic [2:0] DC_IDX = 3'(DC_SAMPLE_BIT);

  logic [SYNC_STAGES-1:0] clk_sync, cs_sync, res_sync, mosi_sync, dc_sync;
  logic [SYNC_STAGES:0]   prime;
  logic clk_hist, cs_hist;
  logic clk_s, cs_s, res_s, mosi_s, dc_s;
  logic clk_rise, cs_fall;

  state_t    state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [6:0] shifter, shifter_d;
  logic       dc_lat, dc_lat_d;
  logic       push, frame_set, overflow_set;
  rx_entry_t  entry, head;
  logic       full, empty;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign res_s  = res_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign dc_s   = dc_sync[SYNC_STAGES-1];

  assign clk_rise = clk_s && !clk_hist;
  // CS low at reset release must not start a frame, so falls count only once the chain holds real samples.
  assign cs_fall  = prime[SYNC_STAGES] && cs_hist && !cs_s;

  // Stage: input synchronisers and edge history
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      clk_sync  <= '1;
      cs_sync   <= '1;
      res_sync  <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      clk_hist  <= 1'b1;
      cs_hist   <= 1'b1;
      prime     <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      res_sync  <= {res_sync[SYNC_STAGES-2:0], spi_res};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      clk_hist  <= clk_s;
      cs_hist   <= cs_s;
      prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Stage: frame FSM and deserialiser
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shifter_d = shifter;
    dc_lat_d  = dc_lat;
    push      = 1'b0;
    frame_set = 1'b0;
    entry.dc   = (bit_cnt == DC_IDX) ? dc_s : dc_lat;
    entry.data = {shifter, mosi_s};
    case (state)
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_s) begin
          frame_set = (bit_cnt != '0);
          bit_cnt_d = '0;
          shifter_d = '0;
          state_d   = IDLE;
        end else if (clk_rise) begin
          shifter_d = {shifter[5:0], mosi_s};
          if (bit_cnt == DC_IDX) dc_lat_d = dc_s;
          push      = (bit_cnt == 3'd7);
          bit_cnt_d = bit_cnt + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!res_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shifter_d = '0;
      push      = 1'b0;
      frame_set = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shifter <= '0;
      dc_lat  <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shifter <= shifter_d;
      dc_lat  <= dc_lat_d;
    end
  end

  spi_oled_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .flush (!res_s),
    .push  (push),
    .din   (entry),
    .pop   (rx_ready),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // When full the FIFO is non-empty, so rx_ready alone means a slot frees this cycle.
  assign overflow_set = push && full && !rx_ready;

  // Stage: sticky error flags (a new event beats clr_err)
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else if (!res_s) begin
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_overflow  <= overflow_set || (rx_overflow && !clr_err);
      rx_frame_err <= frame_set || (rx_frame_err && !clr_err);
    end
  end

  assign rx_valid = !empty;
  assign rx_data  = empty ? 8'h00 : head.data;
  assign rx_dc    = !empty && head.dc;
  assign busy     = (state == SHIFT);

`ifdef SPI_OLED_RX_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic accepted;
  assign accepted = push && (!full || rx_ready);

  // Stage: accepted-byte counters
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cmd_cnt  <= '0;
      data_cnt <= '0;
    end else if (!res_s || clr_err) begin
      cmd_cnt  <= '0;
      data_cnt <= '0;
    end else if (accepted) begin
      if (entry.dc) data_cnt <= sat_inc(data_cnt);
      else          cmd_cnt  <= sat_inc(cmd_cnt);
    end
  end
`endif

endmodule
